// File: rtl/msrv32_trap_controller_pkg.sv
// rtl/msrv32_trap_controller_pkg.sv - shared states, PC-mux codes, cause codes and decode constants
package msrv32_trap_controller_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'd0,
    ST_OPERATING   = 2'd1,
    ST_TRAP_TAKEN  = 2'd2,
    ST_TRAP_RETURN = 2'd3
  } state_t;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT = 2'b01;
  localparam logic [1:0] PC_SRC_EPC  = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_MSI              = 4'd3;
  localparam logic [3:0] CAUSE_MTI              = 4'd7;
  localparam logic [3:0] CAUSE_MEI              = 4'd11;

  localparam logic [4:0]  OPC_SYSTEM = 5'b11100;
  localparam logic [2:0]  F3_PRIV    = 3'b000;
  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;

  typedef struct packed {
    logic       valid;
    logic       i_or_e;
    logic [3:0] cause;
    logic       misaligned;
  } trap_req_t;

  function automatic logic is_priv_op(input logic [4:0]  opcode,
                                      input logic [2:0]  funct3,
                                      input logic [11:0] funct12,
                                      input logic [11:0] match);
    return (opcode == OPC_SYSTEM) && (funct3 == F3_PRIV) && (funct12 == match);
  endfunction

endpackage

// File: rtl/msrv32_trap_controller_if.sv
// rtl/msrv32_trap_controller_if.sv - decode/exception/CSR inputs and trap action outputs of the trap controller
interface msrv32_trap_controller_if;

  logic [4:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [11:0] funct12_in;
  logic        illegal_instr_in;
  logic        misaligned_instr_in;
  logic        misaligned_load_in;
  logic        misaligned_store_in;
  logic        mie_in;
  logic        meie_in;
  logic        mtie_in;
  logic        msie_in;
  logic        meip_in;
  logic        mtip_in;
  logic        msip_in;

  logic        i_or_e_out;
  logic [3:0]  cause_out;
  logic        set_cause_out;
  logic        set_epc_out;
  logic        mie_clear_out;
  logic        mie_set_out;
  logic        instret_inc_out;
  logic        misaligned_exception_out;
  logic [1:0]  pc_src_out;
  logic        flush_out;

  modport master (
    output opcode_in, funct3_in, funct12_in, illegal_instr_in, misaligned_instr_in,
           misaligned_load_in, misaligned_store_in, mie_in, meie_in, mtie_in, msie_in,
           meip_in, mtip_in, msip_in,
    input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
           instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
  );

  modport slave (
    input  opcode_in, funct3_in, funct12_in, illegal_instr_in, misaligned_instr_in,
           misaligned_load_in, misaligned_store_in, mie_in, meie_in, mtie_in, msie_in,
           meip_in, mtip_in, msip_in,
    output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
           instret_inc_out, misaligned_exception_out, pc_src_out, flush_out
  );

endinterface

// File: rtl/msrv32_trap_priority.sv
// rtl/msrv32_trap_priority.sv - combinational priority encoder from trap sources to {valid, i_or_e, cause}
module msrv32_trap_priority
  import msrv32_trap_controller_pkg::*;
(
  input  logic      mei,
  input  logic      msi,
  input  logic      mti,
  input  logic      instr_misaligned,
  input  logic      illegal,
  input  logic      ebreak,
  input  logic      load_misaligned,
  input  logic      store_misaligned,
  input  logic      ecall,
  output trap_req_t req
);

  // Interrupts are checked first so any pending interrupt beats a same-cycle exception.
  always_comb begin
    req = '0;
    if (mei) begin
      req.valid = 1'b1; req.i_or_e = 1'b1; req.cause = CAUSE_MEI;
    end else if (msi) begin
      req.valid = 1'b1; req.i_or_e = 1'b1; req.cause = CAUSE_MSI;
    end else if (mti) begin
      req.valid = 1'b1; req.i_or_e = 1'b1; req.cause = CAUSE_MTI;
    end else if (instr_misaligned) begin
      req.valid = 1'b1; req.cause = CAUSE_INSTR_MISALIGNED; req.misaligned = 1'b1;
    end else if (illegal) begin
      req.valid = 1'b1; req.cause = CAUSE_ILLEGAL_INSTR;
    end else if (ebreak) begin
      req.valid = 1'b1; req.cause = CAUSE_BREAKPOINT;
    end else if (load_misaligned) begin
      req.valid = 1'b1; req.cause = CAUSE_LOAD_MISALIGNED; req.misaligned = 1'b1;
    end else if (store_misaligned) begin
      req.valid = 1'b1; req.cause = CAUSE_STORE_MISALIGNED; req.misaligned = 1'b1;
    end else if (ecall) begin
      req.valid = 1'b1; req.cause = CAUSE_ECALL_M;
    end
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// rtl/msrv32_trap_controller.sv - machine-mode trap sequencer driving CSR trap actions and the PC mux
module msrv32_trap_controller
  import msrv32_trap_controller_pkg::*;
#(
  parameter int RESET_CYCLES = 1
)
(
  input logic                     clk_in,
  input logic                     rst_in,
  msrv32_trap_controller_if.slave bus
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       cause_q;
  logic             i_or_e_q;
  logic             misaligned_q;

  logic       is_ecall, is_ebreak, is_mret;
  logic       irq_mei, irq_msi, irq_mti;
  trap_req_t  req;

  logic       instret_inc, set_epc, set_cause, mie_clear, mie_set, flush;
  logic [1:0] pc_src;

  assign is_ecall  = is_priv_op(bus.opcode_in, bus.funct3_in, bus.funct12_in, F12_ECALL);
  assign is_ebreak = is_priv_op(bus.opcode_in, bus.funct3_in, bus.funct12_in, F12_EBREAK);
  assign is_mret   = is_priv_op(bus.opcode_in, bus.funct3_in, bus.funct12_in, F12_MRET);

  assign irq_mei = bus.mie_in & bus.meie_in & bus.meip_in;
  assign irq_msi = bus.mie_in & bus.msie_in & bus.msip_in;
  assign irq_mti = bus.mie_in & bus.mtie_in & bus.mtip_in;

  msrv32_trap_priority u_priority (
    .mei              (irq_mei),
    .msi              (irq_msi),
    .mti              (irq_mti),
    .instr_misaligned (bus.misaligned_instr_in),
    .illegal          (bus.illegal_instr_in),
    .ebreak           (is_ebreak),
    .load_misaligned  (bus.misaligned_load_in),
    .store_misaligned (bus.misaligned_store_in),
    .ecall            (is_ecall),
    .req              (req)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_RESET;
      hold_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RESET && state_d == ST_RESET) begin
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end else begin
        hold_cnt_q <= '0;
      end
    end
  end

  // Trap info is captured only on entry, so it stays stable until the next trap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cause_q      <= '0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (state_q == ST_OPERATING && req.valid) begin
      cause_q      <= req.cause;
      i_or_e_q     <= req.i_or_e;
      misaligned_q <= req.misaligned;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_src      = PC_SRC_BOOT;
    flush       = 1'b1;
    set_epc     = 1'b0;
    set_cause   = 1'b0;
    mie_clear   = 1'b0;
    mie_set     = 1'b0;
    instret_inc = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_OPERATING;
      end
      ST_OPERATING: begin
        pc_src = PC_SRC_NEXT;
        flush  = 1'b0;
        if (req.valid) begin
          state_d = ST_TRAP_TAKEN;
        end else if (is_mret) begin
          state_d     = ST_TRAP_RETURN;
          instret_inc = 1'b1;
        end else begin
          instret_inc = 1'b1;
        end
      end
      ST_TRAP_TAKEN: begin
        pc_src    = PC_SRC_TRAP;
        set_epc   = 1'b1;
        set_cause = 1'b1;
        mie_clear = 1'b1;
        state_d   = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        pc_src  = PC_SRC_EPC;
        mie_set = 1'b1;
        state_d = ST_OPERATING;
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign bus.i_or_e_out               = i_or_e_q;
  assign bus.cause_out                = cause_q;
  assign bus.misaligned_exception_out = misaligned_q;
  assign bus.set_cause_out            = set_cause;
  assign bus.set_epc_out              = set_epc;
  assign bus.mie_clear_out            = mie_clear;
  assign bus.mie_set_out              = mie_set;
  assign bus.instret_inc_out          = instret_inc;
  assign bus.pc_src_out               = pc_src;
  assign bus.flush_out                = flush;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// tb/tb_msrv32_trap_controller.sv - scoreboard bench for the machine-mode trap controller
module tb_msrv32_trap_controller;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  msrv32_trap_controller_if bus ();

  msrv32_trap_controller #(.RESET_CYCLES(1)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] funct12;
    logic illegal, mis_i, mis_l, mis_s;
    logic mie, meie, mtie, msie, meip, mtip, msip;
  } stim_t;

  typedef struct packed {
    logic [1:0] pc_src;
    logic flush, set_epc, set_cause, mie_clear, mie_set, instret;
    logic       i_or_e;
    logic [3:0] cause;
    logic       mis;
  } obs_t;

  typedef struct {
    string name;
    stim_t stim;
    obs_t  exp;
  } row_t;

  row_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  // Latched trap info the bench expects the DUT to hold.
  logic [3:0] m_cause;
  logic       m_ie, m_mis;

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t sys(input logic [11:0] f12);
    stim_t s = '0;
    s.opcode  = 5'b11100;
    s.funct12 = f12;
    return s;
  endfunction

  function automatic obs_t reset_exp();
    obs_t o = '0;
    o.pc_src = 2'b00;
    o.flush  = 1'b1;
    return o;
  endfunction

  function automatic obs_t op_exp(input logic inc, input logic [3:0] c, input logic ie, input logic mis);
    obs_t o = '0;
    o.pc_src = 2'b01; o.instret = inc; o.cause = c; o.i_or_e = ie; o.mis = mis;
    return o;
  endfunction

  function automatic obs_t taken_exp(input logic [3:0] c, input logic ie, input logic mis);
    obs_t o = '0;
    o.pc_src = 2'b11; o.flush = 1'b1; o.set_epc = 1'b1; o.set_cause = 1'b1; o.mie_clear = 1'b1;
    o.cause = c; o.i_or_e = ie; o.mis = mis;
    return o;
  endfunction

  function automatic obs_t ret_exp(input logic [3:0] c, input logic ie, input logic mis);
    obs_t o = '0;
    o.pc_src = 2'b10; o.flush = 1'b1; o.mie_set = 1'b1;
    o.cause = c; o.i_or_e = ie; o.mis = mis;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pc_src    = bus.pc_src_out;
    o.flush     = bus.flush_out;
    o.set_epc   = bus.set_epc_out;
    o.set_cause = bus.set_cause_out;
    o.mie_clear = bus.mie_clear_out;
    o.mie_set   = bus.mie_set_out;
    o.instret   = bus.instret_inc_out;
    o.i_or_e    = bus.i_or_e_out;
    o.cause     = bus.cause_out;
    o.mis       = bus.misaligned_exception_out;
    return o;
  endfunction

  task automatic drive(input stim_t s);
    bus.opcode_in           = s.opcode;
    bus.funct3_in           = s.funct3;
    bus.funct12_in          = s.funct12;
    bus.illegal_instr_in    = s.illegal;
    bus.misaligned_instr_in = s.mis_i;
    bus.misaligned_load_in  = s.mis_l;
    bus.misaligned_store_in = s.mis_s;
    bus.mie_in              = s.mie;
    bus.meie_in             = s.meie;
    bus.mtie_in             = s.mtie;
    bus.msie_in             = s.msie;
    bus.meip_in             = s.meip;
    bus.mtip_in             = s.mtip;
    bus.msip_in             = s.msip;
  endtask

  task automatic push(input string n, input stim_t s, input obs_t e);
    row_t r;
    r.name = n; r.stim = s; r.exp = e;
    sb_q.push_back(r);
  endtask

  // Trap entry from OPERATING: the trigger cycle, the TRAP_TAKEN cycle, and the return to OPERATING.
  task automatic push_trap(input string n, input stim_t s, input logic [3:0] c, input logic ie, input logic mis);
    push({n, "_trigger"}, s, op_exp(1'b0, m_cause, m_ie, m_mis));
    push({n, "_taken"}, idle(), taken_exp(c, ie, mis));
    push({n, "_after"}, idle(), op_exp(1'b1, c, ie, mis));
    m_cause = c; m_ie = ie; m_mis = mis;
  endtask

  task automatic push_no_trap(input string n, input stim_t s);
    push(n, s, op_exp(1'b1, m_cause, m_ie, m_mis));
    push({n, "_next"}, idle(), op_exp(1'b1, m_cause, m_ie, m_mis));
  endtask

  task automatic test_reset();
    obs_t o;
    row_t r;
    rst_in = 1'b1;
    drive(idle());
    @(negedge clk_in); #1;
    o = observe();
    checks++;
    if (o !== reset_exp()) begin
      failures++;
      $display("FAIL reset_held: got %h expected %h", o, reset_exp());
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    m_cause = 4'd0; m_ie = 1'b0; m_mis = 1'b0;
    push("reset_release", idle(), reset_exp());
    push("reset_exit", idle(), op_exp(1'b1, 4'd0, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_ecall();
    obs_t o;
    row_t r;
    push_trap("ecall", sys(12'h000), 4'd11, 1'b0, 1'b0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_irq_vs_exc();
    obs_t o;
    row_t r;
    stim_t s;
    s = idle(); s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1; s.illegal = 1'b1;
    push_trap("irq_beats_illegal", s, 4'd11, 1'b1, 1'b0);
    s.mie = 1'b0;
    push_trap("masked_irq_illegal", s, 4'd2, 1'b0, 1'b0);
    s = idle(); s.mtie = 1'b1; s.mtip = 1'b1;
    push_no_trap("mti_global_masked", s);
    s = idle(); s.mie = 1'b1; s.meie = 1'b1; s.msie = 1'b1; s.mtie = 1'b1;
    push_no_trap("enabled_not_pending", s);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_mret();
    obs_t o;
    row_t r;
    stim_t s;
    push("mret_issue", sys(12'h302), op_exp(1'b1, m_cause, m_ie, m_mis));
    push("mret_return", idle(), ret_exp(m_cause, m_ie, m_mis));
    push("mret_after", idle(), op_exp(1'b1, m_cause, m_ie, m_mis));
    s = sys(12'h302); s.funct3 = 3'b001;
    push_no_trap("mret_wrong_funct3", s);
    s = sys(12'h302); s.mis_s = 1'b1;
    push_trap("mret_with_store_mis", s, 4'd6, 1'b0, 1'b1);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    row_t r;
    stim_t s;
    s = idle(); s.mis_l = 1'b1; s.mis_s = 1'b1;
    push_trap("load_store_mis", s, 4'd4, 1'b0, 1'b1);
    push_trap("ebreak", sys(12'h001), 4'd3, 1'b0, 1'b0);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_priority();
    obs_t o;
    row_t r;
    stim_t s;
    s = sys(12'h000); s.mis_i = 1'b1; s.illegal = 1'b1;
    push_trap("instr_mis_first", s, 4'd0, 1'b0, 1'b1);
    s = sys(12'h001); s.illegal = 1'b1;
    push_trap("illegal_over_ebreak", s, 4'd2, 1'b0, 1'b0);
    s = sys(12'h001); s.mis_l = 1'b1;
    push_trap("ebreak_over_load_mis", s, 4'd3, 1'b0, 1'b0);
    s = sys(12'h000); s.mis_s = 1'b1;
    push_trap("store_mis_over_ecall", s, 4'd6, 1'b0, 1'b1);
    s = idle(); s.mie = 1'b1; s.msie = 1'b1; s.msip = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1;
    push_trap("msi_over_mti", s, 4'd3, 1'b1, 1'b0);
    s = idle(); s.mie = 1'b1; s.meie = 1'b1; s.meip = 1'b1; s.msie = 1'b1; s.msip = 1'b1;
    push_trap("mei_over_msi", s, 4'd11, 1'b1, 1'b0);
    s = idle(); s.mie = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1;
    push_trap("mti_alone", s, 4'd7, 1'b1, 1'b0);
    s = idle(); s.mie = 1'b1; s.msie = 1'b1; s.msip = 1'b1; s.mis_i = 1'b1;
    push_trap("msi_over_instr_mis", s, 4'd3, 1'b1, 1'b0);
    s = sys(12'h001); s.opcode = 5'b11000;
    push_no_trap("ebreak_wrong_opcode", s);
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    row_t r;
    stim_t s_ill, s_mis;
    s_ill = idle(); s_ill.illegal = 1'b1;
    s_mis = idle(); s_mis.mis_i = 1'b1;
    push("b2b_ecall", sys(12'h000), op_exp(1'b0, m_cause, m_ie, m_mis));
    push("b2b_taken_ignores_input", s_mis, taken_exp(4'd11, 1'b0, 1'b0));
    push("b2b_second_trigger", s_ill, op_exp(1'b0, 4'd11, 1'b0, 1'b0));
    push("b2b_second_taken", idle(), taken_exp(4'd2, 1'b0, 1'b0));
    push("b2b_after", idle(), op_exp(1'b1, 4'd2, 1'b0, 1'b0));
    m_cause = 4'd2; m_ie = 1'b0; m_mis = 1'b0;
    push("ret_issue", sys(12'h302), op_exp(1'b1, m_cause, m_ie, m_mis));
    push("ret_ignores_input", s_ill, ret_exp(m_cause, m_ie, m_mis));
    push("ret_after", idle(), op_exp(1'b1, m_cause, m_ie, m_mis));
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  task automatic test_reset_mid_trap();
    obs_t o;
    row_t r;
    @(negedge clk_in); drive(sys(12'h000));
    @(posedge clk_in); #1;
    drive(idle());
    o = observe();
    checks++;
    if (o !== taken_exp(4'd11, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL mid_trap_taken: got %h expected %h", o, taken_exp(4'd11, 1'b0, 1'b0));
    end
    rst_in = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== reset_exp()) begin
      failures++;
      $display("FAIL mid_trap_async_reset: got %h expected %h", o, reset_exp());
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    m_cause = 4'd0; m_ie = 1'b0; m_mis = 1'b0;
    push("mid_reset_release", idle(), reset_exp());
    push("mid_reset_exit", idle(), op_exp(1'b1, 4'd0, 1'b0, 1'b0));
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      @(negedge clk_in); drive(r.stim); #1;
      o = observe();
      checks++;
      if (o !== r.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", r.name, o, r.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ecall();
    test_irq_vs_exc();
    test_mret();
    test_misaligned();
    test_priority();
    test_back_to_back();
    test_reset_mid_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
